// File: rtl/slow_fpu_sequencer_if.sv
// Handshake bundle between exec stage, iterative FP core and the slow FPU sequencer.
// master = sequencer side, slave = exec stage / core side.
interface slow_fpu_sequencer_if;
    logic        slow_fpu_en_pulse;
    logic [2:0]  op_e;
    logic [31:0] src1_e;
    logic [31:0] src2_e;
    logic        stall_e;
    logic        core_start;
    logic [2:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_result;
    logic        slow_fpu_valid;
    logic [31:0] slow_fpu_result;
    logic        busy;
    logic        fpu_err;

    modport master (
        input  slow_fpu_en_pulse, op_e, src1_e, src2_e, stall_e,
        input  core_done, core_result,
        output core_start, core_op, core_a, core_b,
        output slow_fpu_valid, slow_fpu_result, busy, fpu_err
    );

    modport slave (
        output slow_fpu_en_pulse, op_e, src1_e, src2_e, stall_e,
        output core_done, core_result,
        input  core_start, core_op, core_a, core_b,
        input  slow_fpu_valid, slow_fpu_result, busy, fpu_err
    );
endinterface

// File: rtl/slow_fpu_sequencer.sv
// Launches slow FP ops on an iterative core and holds the result for exec.
// Optional watchdog: define SLOW_FPU_TIMEOUT_EN.
module slow_fpu_sequencer (
    input logic                  clk,
    input logic                  rst_n,
    slow_fpu_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

`ifdef SLOW_FPU_TIMEOUT_EN
    logic [5:0] wd_cnt;
    logic       err_q;

    assign bus.fpu_err = err_q;
`else
    assign bus.fpu_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state               <= IDLE;
            bus.core_start      <= 1'b0;
            bus.core_op         <= 3'd0;
            bus.core_a          <= 32'd0;
            bus.core_b          <= 32'd0;
            bus.slow_fpu_valid  <= 1'b0;
            bus.slow_fpu_result <= 32'd0;
            bus.busy            <= 1'b0;
`ifdef SLOW_FPU_TIMEOUT_EN
            wd_cnt              <= 6'd0;
            err_q               <= 1'b0;
`endif
        end else begin
            bus.core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.slow_fpu_en_pulse) begin
                        state          <= BUSY;
                        bus.core_start <= 1'b1;
                        bus.core_op    <= bus.op_e;
                        bus.core_a     <= bus.src1_e;
                        bus.core_b     <= bus.src2_e;
                        bus.busy       <= 1'b1;
`ifdef SLOW_FPU_TIMEOUT_EN
                        wd_cnt         <= 6'd0;
`endif
                    end
                end
                BUSY: begin
                    // core_start high marks the launch cycle; done there is stale
                    if (bus.core_done && !bus.core_start) begin
                        state               <= DONE;
                        bus.slow_fpu_valid  <= 1'b1;
                        bus.slow_fpu_result <= bus.core_result;
                    end
`ifdef SLOW_FPU_TIMEOUT_EN
                    else if (wd_cnt == 6'd63) begin
                        state               <= DONE;
                        bus.slow_fpu_valid  <= 1'b1;
                        bus.slow_fpu_result <= 32'h7FC0_0000;
                        err_q               <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 6'd1;
                    end
`endif
                end
                DONE: begin
                    if (!bus.stall_e) begin
                        state              <= IDLE;
                        bus.slow_fpu_valid <= 1'b0;
                        bus.busy           <= 1'b0;
                    end
                end
                default: begin
                    state              <= IDLE;
                    bus.slow_fpu_valid <= 1'b0;
                    bus.busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slow_fpu_sequencer.sv
// Self-checking bench for slow_fpu_sequencer: table + random transactions
// against a cycle-window reference model.
module tb_slow_fpu_sequencer;
    logic clk;
    logic rst_n;

    slow_fpu_sequencer_if bus();

    slow_fpu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
        int          stl;
        bit          junk;
    } vec_t;

    int n_tests;
    int n_fail;

    logic [31:0] m_res;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic chk_outputs(input logic s, input logic v,
                               input logic bz);
        chk("core_start", {31'd0, bus.core_start}, {31'd0, s});
        chk("valid", {31'd0, bus.slow_fpu_valid}, {31'd0, v});
        chk("busy", {31'd0, bus.busy}, {31'd0, bz});
        chk("result", bus.slow_fpu_result, m_res);
        chk("core_op", {29'd0, bus.core_op}, {29'd0, m_op});
        chk("core_a", bus.core_a, m_a);
        chk("core_b", bus.core_b, m_b);
        chk("fpu_err", {31'd0, bus.fpu_err}, 32'd0);
    endtask

    task automatic idle_inputs();
        bus.slow_fpu_en_pulse = 1'b0;
        bus.op_e              = 3'd0;
        bus.src1_e            = 32'd0;
        bus.src2_e            = 32'd0;
        bus.stall_e           = 1'b0;
        bus.core_done         = 1'b0;
        bus.core_result       = 32'd0;
    endtask

    // Model: pulse in cycle 0 -> start in 1, valid over [2+L, 2+L+S], idle after
    task automatic run_txn(input vec_t v);
        int last;
        bit in_busy;
        bit in_done;
        last = 2 + v.lat + v.stl;
        for (int c = 0; c <= last; c++) begin
            in_busy = (c >= 1) && (c < 2 + v.lat);
            in_done = (c >= 2 + v.lat);
            if (c == 0) begin
                bus.slow_fpu_en_pulse = 1'b1;
                bus.op_e   = v.op;
                bus.src1_e = v.a;
                bus.src2_e = v.b;
            end else begin
                bus.slow_fpu_en_pulse = v.junk && ($urandom_range(0, 2) == 0);
                bus.op_e   = 3'($urandom);
                bus.src1_e = $urandom;
                bus.src2_e = $urandom;
            end
            if (c == 1 + v.lat) begin
                bus.core_done   = 1'b1;
                bus.core_result = v.r;
            end else begin
                bus.core_done   = v.junk && ((c == 1) ||
                                  (in_done && $urandom_range(0, 1) == 1));
                bus.core_result = $urandom;
            end
            bus.stall_e = (c < last) ? 1'b1 : $urandom_range(0, 1) == 1 && in_busy;
            tick();
            if (c == 0) begin
                m_op = v.op;
                m_a  = v.a;
                m_b  = v.b;
            end
            if (c + 1 == 2 + v.lat) m_res = v.r;
            chk_outputs((c + 1) == 1,
                        (c + 1 >= 2 + v.lat) && (c + 1 <= last),
                        (c + 1 >= 1) && (c + 1 <= last));
        end
        idle_inputs();
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_res   = 32'd0;
        m_op    = 3'd0;
        m_a     = 32'd0;
        m_b     = 32'd0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk_outputs(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_outputs(1'b0, 1'b0, 1'b0);

        tbl.push_back('{3'b000, 32'h4040_0000, 32'h4000_0000,
                        32'h3FC0_0000, 10, 0, 1'b0});
        tbl.push_back('{3'b001, 32'h4080_0000, 32'h0000_0000,
                        32'h4000_0000, 3, 5, 1'b0});
        tbl.push_back('{3'b010, 32'hC0A0_0000, 32'h1234_5678,
                        32'hFFFF_FFFB, 6, 2, 1'b1});
        tbl.push_back('{3'b011, 32'h0000_0007, 32'hDEAD_BEEF,
                        32'h40E0_0000, 1, 0, 1'b0});
        tbl.push_back('{3'b111, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
                        32'h0BAD_F00D, 1, 3, 1'b1});
        tbl.push_back('{3'b100, 32'hFFFF_FFFF, 32'h0000_0001,
                        32'h0000_0000, 15, 1, 1'b1});
        foreach (tbl[i]) run_txn(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            rv.op   = 3'($urandom);
            rv.a    = $urandom;
            rv.b    = $urandom;
            rv.r    = $urandom;
            rv.lat  = $urandom_range(1, 20);
            rv.stl  = $urandom_range(0, 6);
            rv.junk = $urandom_range(0, 1) == 1;
            run_txn(rv);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk_outputs(1'b0, 1'b0, 1'b0);
            end
        end

        // reset in the middle of BUSY, then a late core_done
        bus.slow_fpu_en_pulse = 1'b1;
        bus.op_e   = 3'b001;
        bus.src1_e = 32'h1111_2222;
        bus.src2_e = 32'h3333_4444;
        bus.stall_e = 1'b1;
        tick();
        bus.slow_fpu_en_pulse = 1'b0;
        m_op = 3'b001;
        m_a  = 32'h1111_2222;
        m_b  = 32'h3333_4444;
        chk_outputs(1'b1, 1'b0, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_res = 32'd0;
        m_op  = 3'd0;
        m_a   = 32'd0;
        m_b   = 32'd0;
        chk_outputs(1'b0, 1'b0, 1'b0);
        bus.core_done   = 1'b1;
        bus.core_result = 32'hCAFE_BABE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_outputs(1'b0, 1'b0, 1'b0);
        end
        idle_inputs();

        // reset in DONE while stalled
        rv = '{3'b000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000,
               2, 0, 1'b0};
        bus.slow_fpu_en_pulse = 1'b1;
        bus.op_e   = rv.op;
        bus.src1_e = rv.a;
        bus.src2_e = rv.b;
        bus.stall_e = 1'b1;
        tick();
        bus.slow_fpu_en_pulse = 1'b0;
        tick();
        bus.core_done   = 1'b1;
        bus.core_result = rv.r;
        tick();
        bus.core_done = 1'b0;
        m_op  = rv.op;
        m_a   = rv.a;
        m_b   = rv.b;
        m_res = rv.r;
        chk_outputs(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_res = 32'd0;
        m_op  = 3'd0;
        m_a   = 32'd0;
        m_b   = 32'd0;
        chk_outputs(1'b0, 1'b0, 1'b0);
        idle_inputs();
        tick();

`ifdef SLOW_FPU_TIMEOUT_EN
        begin
            int waited;
            bus.slow_fpu_en_pulse = 1'b1;
            bus.op_e   = 3'b000;
            bus.src1_e = 32'h4040_0000;
            bus.src2_e = 32'h0000_0000;
            bus.stall_e = 1'b1;
            tick();
            bus.slow_fpu_en_pulse = 1'b0;
            waited = 0;
            while (bus.slow_fpu_valid !== 1'b1 && waited < 100) begin
                tick();
                waited++;
            end
            n_tests++;
            if (waited < 60 || waited > 66) begin
                n_fail++;
                $display("FAIL timeout_latency: got %0d cycles expected ~63",
                         waited);
            end
            chk("timeout_result", bus.slow_fpu_result, 32'h7FC0_0000);
            chk("timeout_err", {31'd0, bus.fpu_err}, 32'd1);
            bus.stall_e = 1'b0;
            tick();
            tick();
            chk("err_sticky", {31'd0, bus.fpu_err}, 32'd1);
            chk("timeout_valid_drop", {31'd0, bus.slow_fpu_valid}, 32'd0);
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("err_reset", {31'd0, bus.fpu_err}, 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/slow_fpu_sequencer.md
SLOW_FPU_SEQUENCER -- requirements
Module: slow_fpu_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: slow_fpu_en_pulse  in  1  one-cycle launch request from hazard unit.
REQ-004 SHALL have port: op_e  in  3  slow op code from exec stage: 000 fdiv, 001 fsqrt, 010 fcvt.w.s, 011 fcvt.s.w, others reserved.
REQ-005 SHALL have ports: src1_e, src2_e  in  32  operands from exec stage, forwarding already applied.
REQ-006 SHALL have port: stall_e  in  1  exec-stage stall; 0 means the exec instruction advances this cycle.
REQ-007 SHALL have ports: core_start  out  1, core_op  out  3, core_a/core_b  out  32  iterative-core launch and held operands.
REQ-008 SHALL have ports: core_done  in  1, core_result  in  32  one-cycle completion from iterative core.
REQ-009 SHALL have ports: slow_fpu_valid  out  1, slow_fpu_result  out  32  result to exec stage.
REQ-010 SHALL have port: busy  out  1  high in BUSY or DONE.
REQ-011 SHALL have port: fpu_err  out  1  sticky error flag; drives 0 when SLOW_FPU_TIMEOUT_EN is undefined.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 In IDLE with slow_fpu_en_pulse=1: SHALL latch op_e/src1_e/src2_e into core_op/core_a/core_b, go to BUSY.
REQ-014 SHALL assert core_start for exactly the first BUSY cycle (registered, one cycle after the pulse).
REQ-015 core_op/core_a/core_b SHALL stay constant from latch until return to IDLE.
REQ-016 In BUSY with core_done=1 on a cycle after core_start: SHALL register core_result into slow_fpu_result, set slow_fpu_valid, go to DONE.
REQ-017 core_done on the core_start cycle SHALL be ignored; minimum core latency is 1 cycle.
REQ-018 Latency: pulse at t, core_start at t+1, core_done at t+1+L -> slow_fpu_valid high from t+2+L.
REQ-019 In DONE: slow_fpu_valid and slow_fpu_result SHALL hold while stall_e=1, independent of duration.
REQ-020 In DONE with stall_e=0: slow_fpu_valid SHALL be 0 from the next cycle; state SHALL return to IDLE; result register holds its last value.
REQ-021 slow_fpu_en_pulse in BUSY or DONE SHALL be ignored with no state change.
REQ-022 core_done in IDLE or DONE SHALL be ignored.
REQ-023 Reserved op codes SHALL be launched unmodified; result is whatever the core returns.
REQ-024 A new pulse SHALL be accepted the first IDLE cycle after DONE exit, giving back-to-back issue.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, slow_fpu_valid=0, core_start=0, busy=0, fpu_err=0, slow_fpu_result=0, core_op/core_a/core_b=0.
REQ-026 Reset in BUSY or DONE SHALL abandon the operation; a later core_done SHALL be ignored.

Configuration
REQ-027 Macro SLOW_FPU_TIMEOUT_EN defined: SHALL have a 6-bit watchdog, cleared on entry to BUSY and counting each BUSY cycle; at count 63 without core_done, SHALL return 32'h7FC00000 as result, enter DONE, and set fpu_err (sticky until reset).
REQ-028 Macro SLOW_FPU_TIMEOUT_EN undefined: SHALL have no watchdog; BUSY lasts until core_done; fpu_err tied 0.

Verification
REQ-029 Pulse, op=000, src1=0x40400000, src2=0x40000000; core_done after 10 cycles with 0x3FC00000; stall_e=0 from valid -> core_start 1 cycle at t+1, valid at t+12 with result 0x3FC00000 for one cycle.
REQ-030 Valid asserted with stall_e held 1 for 5 cycles -> valid/result stable 5 cycles, drop the cycle after stall_e falls.
REQ-031 Second pulse during BUSY with different operands -> core_a/core_b unchanged, no second core_start.
REQ-032 rst_n=0 mid-BUSY, then core_done=1 -> all outputs at reset values, valid stays 0.
REQ-033 Back-to-back: pulse the cycle after DONE exit -> new core_start next cycle with new operands.
REQ-034 SLOW_FPU_TIMEOUT_EN defined, core_done never asserted -> after 63 BUSY cycles result=0x7FC00000, valid=1, fpu_err=1 until reset.
